// File: rtl/rename_register_file.sv
// rename_register_file: architectural register file with rename tags, fed by decoder issue and ROB commit/exception.
// Ports: clk, rst (async active-low); decoder issue (rs1/rs2/rd/pc); ROB commit (rd/pc/data) and exception;
// registered operand outputs to the reservation station (data, busy, tag per source, is_valid_to_rs).
// Optional: define RF_COMMIT_FORWARD_EN to bypass a same-cycle matching commit into the operand read.
module rename_register_file #(
  parameter int RegNum        = 32,
  parameter int RegAddrLength = 4,
  parameter int DataLength    = 31,
  parameter int PcLength      = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   is_issue_from_decoder,
  input  logic [RegAddrLength:0] rs1_from_decoder,
  input  logic [RegAddrLength:0] rs2_from_decoder,
  input  logic [RegAddrLength:0] rd_from_decoder,
  input  logic [PcLength:0]      pc_from_decoder,
  input  logic                   is_commit_from_rob,
  input  logic [RegAddrLength:0] commit_rd_from_rob,
  input  logic [PcLength:0]      commit_pc_from_rob,
  input  logic [DataLength:0]    commit_data_from_rob,
  input  logic                   is_exception_from_rob,
  output logic [DataLength:0]    data1_to_rs,
  output logic [DataLength:0]    data2_to_rs,
  output logic                   is_busy1_to_rs,
  output logic                   is_busy2_to_rs,
  output logic [PcLength:0]      tag1_to_rs,
  output logic [PcLength:0]      tag2_to_rs,
  output logic                   is_valid_to_rs
);
  logic [DataLength:0] data_q [RegNum];
  logic [PcLength:0]   tag_q  [RegNum];
  logic [RegNum-1:0]   busy_q;
  logic                take;
  logic                b1, b2;
  logic [PcLength:0]   t1, t2;
  logic [DataLength:0] d1, d2;

  assign take = is_issue_from_decoder && !is_exception_from_rob;

  // Reads use pre-edge state, so an instruction renaming its own source sees the old mapping.
  function automatic void read_src(input logic [RegAddrLength:0] rs, output logic busy,
                                   output logic [PcLength:0] tag, output logic [DataLength:0] data);
    logic pend, fwd;
    pend = rs != '0 && busy_q[rs];
`ifdef RF_COMMIT_FORWARD_EN
    fwd = pend && is_commit_from_rob && commit_rd_from_rob == rs && commit_pc_from_rob == tag_q[rs];
`else
    fwd = 1'b0;
`endif
    busy = pend && !fwd;
    tag  = busy ? tag_q[rs] : '0;
    data = fwd ? commit_data_from_rob : (pend || rs == '0) ? '0 : data_q[rs];
  endfunction

  always_comb begin
    read_src(rs1_from_decoder, b1, t1, d1);
    read_src(rs2_from_decoder, b2, t2, d2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q         <= '0;
      for (int i = 0; i < RegNum; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      data1_to_rs    <= '0;
      data2_to_rs    <= '0;
      is_busy1_to_rs <= 1'b0;
      is_busy2_to_rs <= 1'b0;
      tag1_to_rs     <= '0;
      tag2_to_rs     <= '0;
      is_valid_to_rs <= 1'b0;
    end else begin
      // Commit data always lands (even on exception); busy clears only if this commit is still the owner.
      if (is_commit_from_rob && commit_rd_from_rob != '0) begin
        data_q[commit_rd_from_rob] <= commit_data_from_rob;
        if (tag_q[commit_rd_from_rob] == commit_pc_from_rob) busy_q[commit_rd_from_rob] <= 1'b0;
      end
      // Later assignments override the commit's busy clear: exception flushes all, issue re-claims rd.
      if (is_exception_from_rob) begin
        busy_q <= '0;
        for (int i = 0; i < RegNum; i++) tag_q[i] <= '0;
      end else if (is_issue_from_decoder && rd_from_decoder != '0) begin
        busy_q[rd_from_decoder] <= 1'b1;
        tag_q[rd_from_decoder]  <= pc_from_decoder;
      end
      is_valid_to_rs <= take;
      if (take) begin
        data1_to_rs    <= d1;
        data2_to_rs    <= d2;
        is_busy1_to_rs <= b1;
        is_busy2_to_rs <= b2;
        tag1_to_rs     <= t1;
        tag2_to_rs     <= t2;
      end
    end
  end
endmodule

// File: tb/tb_rename_register_file.sv
// tb_rename_register_file: directed self-checking bench for rename_register_file.
module tb_rename_register_file;
  logic        clk = 1'b0;
  logic        rst;
  logic        is_issue_from_decoder;
  logic [4:0]  rs1_from_decoder, rs2_from_decoder, rd_from_decoder;
  logic [31:0] pc_from_decoder;
  logic        is_commit_from_rob;
  logic [4:0]  commit_rd_from_rob;
  logic [31:0] commit_pc_from_rob, commit_data_from_rob;
  logic        is_exception_from_rob;
  logic [31:0] data1_to_rs, data2_to_rs, tag1_to_rs, tag2_to_rs;
  logic        is_busy1_to_rs, is_busy2_to_rs, is_valid_to_rs;
  int          checks = 0;
  int          errors = 0;

  rename_register_file dut (
    .clk(clk), .rst(rst),
    .is_issue_from_decoder(is_issue_from_decoder),
    .rs1_from_decoder(rs1_from_decoder), .rs2_from_decoder(rs2_from_decoder),
    .rd_from_decoder(rd_from_decoder), .pc_from_decoder(pc_from_decoder),
    .is_commit_from_rob(is_commit_from_rob), .commit_rd_from_rob(commit_rd_from_rob),
    .commit_pc_from_rob(commit_pc_from_rob), .commit_data_from_rob(commit_data_from_rob),
    .is_exception_from_rob(is_exception_from_rob),
    .data1_to_rs(data1_to_rs), .data2_to_rs(data2_to_rs),
    .is_busy1_to_rs(is_busy1_to_rs), .is_busy2_to_rs(is_busy2_to_rs),
    .tag1_to_rs(tag1_to_rs), .tag2_to_rs(tag2_to_rs),
    .is_valid_to_rs(is_valid_to_rs)
  );

  always #5 clk = ~clk;

  task automatic idle();
    is_issue_from_decoder = 0; rs1_from_decoder = 0; rs2_from_decoder = 0; rd_from_decoder = 0;
    pc_from_decoder = 0; is_commit_from_rob = 0; commit_rd_from_rob = 0; commit_pc_from_rob = 0;
    commit_data_from_rob = 0; is_exception_from_rob = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] pc);
    is_issue_from_decoder = 1; rs1_from_decoder = rs1; rs2_from_decoder = rs2;
    rd_from_decoder = rd; pc_from_decoder = pc;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] data);
    is_commit_from_rob = 1; commit_rd_from_rob = rd; commit_pc_from_rob = pc; commit_data_from_rob = data;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    #2;
    checks++; if (is_valid_to_rs !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", is_valid_to_rs); end
    checks++; if (data1_to_rs !== 32'h0) begin errors++; $display("FAIL reset_data1 got %h exp 0", data1_to_rs); end
    checks++; if ({is_busy1_to_rs, is_busy2_to_rs} !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp 00", {is_busy1_to_rs, is_busy2_to_rs}); end
    checks++; if (tag2_to_rs !== 32'h0) begin errors++; $display("FAIL reset_tag2 got %h exp 0", tag2_to_rs); end
    step(); step();
    rst = 1;
  endtask

  task automatic test_issue_basic();
    issue(5, 0, 3, 32'h100); step();
    checks++; if (is_valid_to_rs !== 1'b1) begin errors++; $display("FAIL issue_valid got %b exp 1", is_valid_to_rs); end
    checks++; if (is_busy1_to_rs !== 1'b0 || data1_to_rs !== 32'h0) begin errors++; $display("FAIL issue_src1 got busy %b data %h exp busy 0 data 0", is_busy1_to_rs, data1_to_rs); end
    checks++; if (is_busy2_to_rs !== 1'b0) begin errors++; $display("FAIL issue_src2 got busy %b exp 0", is_busy2_to_rs); end
    step();
    checks++; if (is_valid_to_rs !== 1'b0) begin errors++; $display("FAIL valid_pulse got %b exp 0", is_valid_to_rs); end
    issue(3, 3, 6, 32'h104); step();
    checks++; if (is_busy1_to_rs !== 1'b1 || tag1_to_rs !== 32'h100 || data1_to_rs !== 32'h0) begin errors++; $display("FAIL renamed_src1 got busy %b tag %h data %h exp 1 100 0", is_busy1_to_rs, tag1_to_rs, data1_to_rs); end
    checks++; if (is_busy2_to_rs !== 1'b1 || tag2_to_rs !== 32'h100) begin errors++; $display("FAIL renamed_src2 got busy %b tag %h exp 1 100", is_busy2_to_rs, tag2_to_rs); end
  endtask

  task automatic test_self_rename();
    issue(6, 0, 6, 32'h110); step();
    checks++; if (is_busy1_to_rs !== 1'b1 || tag1_to_rs !== 32'h104) begin errors++; $display("FAIL self_rename got busy %b tag %h exp 1 104", is_busy1_to_rs, tag1_to_rs); end
    commit(6, 32'h110, 32'h66); step();
  endtask

  task automatic test_commit();
    commit(3, 32'h100, 32'hDEADBEEF); step();
    issue(3, 0, 0, 32'h0); step();
    checks++; if (is_busy1_to_rs !== 1'b0 || data1_to_rs !== 32'hDEADBEEF || tag1_to_rs !== 32'h0) begin errors++; $display("FAIL commit_read got busy %b data %h tag %h exp 0 deadbeef 0", is_busy1_to_rs, data1_to_rs, tag1_to_rs); end
  endtask

  task automatic test_younger_producer();
    issue(0, 0, 3, 32'h100); step();
    issue(0, 0, 3, 32'h104); step();
    commit(3, 32'h100, 32'h7); step();
    issue(3, 6, 0, 32'h0); step();
    checks++; if (is_busy1_to_rs !== 1'b1 || tag1_to_rs !== 32'h104 || data1_to_rs !== 32'h0) begin errors++; $display("FAIL younger_owner got busy %b tag %h data %h exp 1 104 0", is_busy1_to_rs, tag1_to_rs, data1_to_rs); end
    checks++; if (dut.data_q[3] !== 32'h7) begin errors++; $display("FAIL younger_data got %h exp 7", dut.data_q[3]); end
    checks++; if (is_busy2_to_rs !== 1'b0 || data2_to_rs !== 32'h66) begin errors++; $display("FAIL x6_read got busy %b data %h exp 0 66", is_busy2_to_rs, data2_to_rs); end
  endtask

  task automatic test_back_to_back();
    commit(4, 32'h200, 32'h9); issue(0, 0, 4, 32'h208); step();
    issue(4, 0, 0, 32'h0); step();
    checks++; if (is_busy1_to_rs !== 1'b1 || tag1_to_rs !== 32'h208) begin errors++; $display("FAIL issue_wins got busy %b tag %h exp 1 208", is_busy1_to_rs, tag1_to_rs); end
    commit(4, 32'h208, 32'h1); step();
    issue(0, 4, 0, 32'h0); step();
    checks++; if (is_busy2_to_rs !== 1'b0 || data2_to_rs !== 32'h1) begin errors++; $display("FAIL x4_after_commit got busy %b data %h exp 0 1", is_busy2_to_rs, data2_to_rs); end
  endtask

  task automatic test_exception();
    issue(0, 0, 1, 32'h400); step();
    issue(0, 0, 2, 32'h404); step();
    issue(0, 0, 7, 32'h408); step();
    step();
    is_exception_from_rob = 1; commit(1, 32'h400, 32'h44); issue(1, 2, 9, 32'h40C); step();
    checks++; if (is_valid_to_rs !== 1'b0) begin errors++; $display("FAIL exc_no_valid got %b exp 0", is_valid_to_rs); end
    checks++; if (dut.busy_q !== 32'h0) begin errors++; $display("FAIL exc_busy_clear got %h exp 0", dut.busy_q); end
    issue(1, 2, 0, 32'h0); step();
    checks++; if (is_busy1_to_rs !== 1'b0 || data1_to_rs !== 32'h44) begin errors++; $display("FAIL exc_link got busy %b data %h exp 0 44", is_busy1_to_rs, data1_to_rs); end
    checks++; if (is_busy2_to_rs !== 1'b0 || data2_to_rs !== 32'h0) begin errors++; $display("FAIL exc_x2 got busy %b data %h exp 0 0", is_busy2_to_rs, data2_to_rs); end
    issue(7, 3, 0, 32'h0); step();
    checks++; if (is_busy1_to_rs !== 1'b0 || is_busy2_to_rs !== 1'b0 || data2_to_rs !== 32'h7) begin errors++; $display("FAIL exc_x7_x3 got busy %b%b data2 %h exp 00 7", is_busy1_to_rs, is_busy2_to_rs, data2_to_rs); end
  endtask

  task automatic test_x0();
    issue(0, 0, 0, 32'h300); step();
    commit(0, 32'h300, 32'h5); step();
    issue(0, 0, 0, 32'h0); step();
    checks++; if (is_busy1_to_rs !== 1'b0 || data1_to_rs !== 32'h0 || data2_to_rs !== 32'h0) begin errors++; $display("FAIL x0 got busy %b data1 %h data2 %h exp 0 0 0", is_busy1_to_rs, data1_to_rs, data2_to_rs); end
    checks++; if (dut.busy_q[0] !== 1'b0) begin errors++; $display("FAIL x0_busy got %b exp 0", dut.busy_q[0]); end
  endtask

  task automatic test_forward();
    issue(0, 0, 3, 32'h500); step();
    commit(3, 32'h500, 32'h55); issue(3, 0, 0, 32'h0); step();
`ifdef RF_COMMIT_FORWARD_EN
    checks++; if (is_busy1_to_rs !== 1'b0 || data1_to_rs !== 32'h55 || tag1_to_rs !== 32'h0) begin errors++; $display("FAIL forward got busy %b data %h tag %h exp 0 55 0", is_busy1_to_rs, data1_to_rs, tag1_to_rs); end
`else
    checks++; if (is_busy1_to_rs !== 1'b1 || tag1_to_rs !== 32'h500 || data1_to_rs !== 32'h0) begin errors++; $display("FAIL no_forward got busy %b tag %h data %h exp 1 500 0", is_busy1_to_rs, tag1_to_rs, data1_to_rs); end
`endif
    issue(3, 0, 0, 32'h0); step();
    checks++; if (is_busy1_to_rs !== 1'b0 || data1_to_rs !== 32'h55) begin errors++; $display("FAIL after_forward got busy %b data %h exp 0 55", is_busy1_to_rs, data1_to_rs); end
  endtask

  task automatic test_async_reset();
    issue(0, 0, 5, 32'h600); step();
    issue(5, 0, 0, 32'h0); step();
    checks++; if (is_valid_to_rs !== 1'b1 || is_busy1_to_rs !== 1'b1 || tag1_to_rs !== 32'h600) begin errors++; $display("FAIL pre_reset got valid %b busy %b tag %h exp 1 1 600", is_valid_to_rs, is_busy1_to_rs, tag1_to_rs); end
    #2 rst = 0;
    #1;
    checks++; if (is_valid_to_rs !== 1'b0 || is_busy1_to_rs !== 1'b0 || tag1_to_rs !== 32'h0) begin errors++; $display("FAIL async_outputs got valid %b busy %b tag %h exp 0 0 0", is_valid_to_rs, is_busy1_to_rs, tag1_to_rs); end
    checks++; if (dut.busy_q[5] !== 1'b0) begin errors++; $display("FAIL async_x5 got %b exp 0", dut.busy_q[5]); end
    issue(0, 0, 8, 32'h700); step();
    checks++; if (is_valid_to_rs !== 1'b0) begin errors++; $display("FAIL reset_drops_issue got %b exp 0", is_valid_to_rs); end
    rst = 1;
    issue(8, 5, 0, 32'h0); step();
    checks++; if (is_busy1_to_rs !== 1'b0 || is_busy2_to_rs !== 1'b0 || data1_to_rs !== 32'h0) begin errors++; $display("FAIL post_reset got busy %b%b data1 %h exp 00 0", is_busy1_to_rs, is_busy2_to_rs, data1_to_rs); end
  endtask

  initial begin
    test_reset();
    test_issue_basic();
    test_self_rename();
    test_commit();
    test_younger_producer();
    test_back_to_back();
    test_exception();
    test_x0();
    test_forward();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rename_register_file.md
Name: rename_register_file

Overview:
- Architectural register file with rename tags; the commit-side consumer of the reorder buffer's commit/exception bus.
- Issue-stage path: decoder reads operands and claims rd.
  - Each source returns either committed data, or busy plus the producing instruction's PC tag.
- Commit path: ROB commits write data and release tags.
- Exception path: an ROB exception clears all in-flight renames.

Parameters:
- RegNum, 32, number of architectural registers (x0..x31).
- RegAddrLength, 4, MSB index of register address (address width 5).
- DataLength, 31, MSB index of data word.
- PcLength, 31, MSB index of PC/tag.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- is_issue_from_decoder  input  1  issue valid this cycle.
- rs1_from_decoder  input  5  source 1 address.
- rs2_from_decoder  input  5  source 2 address.
- rd_from_decoder  input  5  destination address being renamed.
- pc_from_decoder  input  32  issuing instruction PC (becomes rd tag).
- is_commit_from_rob  input  1  commit valid.
- commit_rd_from_rob  input  5  committed destination.
- commit_pc_from_rob  input  32  committed instruction PC.
- commit_data_from_rob  input  32  committed result.
- is_exception_from_rob  input  1  mispredict/flush.
- data1_to_rs  output  32  source 1 value.
- data2_to_rs  output  32  source 2 value.
- is_busy1_to_rs  output  1  source 1 pending; tag1 valid.
- is_busy2_to_rs  output  1  source 2 pending; tag2 valid.
- tag1_to_rs  output  32  PC of source 1 producer.
- tag2_to_rs  output  32  PC of source 2 producer.
- is_valid_to_rs  output  1  operand outputs valid (registered issue).

Behaviour:
- Storage:
  - data[RegNum], busy[RegNum], tag[RegNum].
  - Reset clears all data, busy and tag to 0.
  - All outputs reset to 0.
- Latency: operands registered.
  - Issue at edge N appears on outputs after edge N.
  - is_valid_to_rs is high for exactly one cycle per accepted issue.
- Read rules, per source, evaluated on state before this edge's updates:
  - Source busy: output busy=1, tag=tag[rs], data=0.
  - Source not busy: output busy=0, tag=0, data=data[rs].
  - rs==0: always busy=0, data=0.
- Read-after-rename within one issue (rd equal to rs1 or rs2): the read sees the OLD mapping, never the instruction's own tag.
- Commit (is_commit_from_rob=1, commit_rd!=0):
  - data[commit_rd] <= commit_data.
  - busy[commit_rd] is cleared only if tag[commit_rd]==commit_pc; otherwise a younger producer owns it and busy stays set.
- Issue (is_issue_from_decoder=1, no exception, rd!=0): busy[rd]<=1, tag[rd]<=pc_from_decoder.
- Simultaneous commit and issue to the same rd: data is written, and busy/tag take the issue values (issue wins).
- Exception (is_exception_from_rob=1):
  - All busy bits cleared; all tags cleared.
  - is_valid_to_rs <= 0 and the issue is dropped (no rename, no output).
  - A commit in the same cycle still writes data (the jal/jalr link value must land).
- x0: never written, never busy, in any case.
- Reset asserted mid-operation: state clears immediately (asynchronously), regardless of clk; pending issue is lost.

Optional Feature:
- Macro RF_COMMIT_FORWARD_EN.
- When defined, same-cycle commit bypass on reads: if a source is busy, is_commit_from_rob=1, commit_rd==rs and commit_pc==tag[rs], output busy=0, tag=0, data=commit_data.
  - Also applies when the exception coincides with the read; in that case no issue occurs.
- When undefined: the read returns busy=1 with the old tag. The RS must capture the value from the commit bus one cycle later.

Test Plan:
- Reset then issue rs1=5, rs2=0, rd=3, pc=0x100 -> next cycle is_valid=1, busy1=0, data1=0, busy2=0. A second issue reading rs1=3 returns busy1=1, tag1=0x100.
- Commit rd=3, pc=0x100, data=0xDEADBEEF -> busy[3] cleared. A later read of x3 gives data=0xDEADBEEF, busy=0.
- Issue rd=3 pc=0x100, then issue rd=3 pc=0x104, then commit rd=3 pc=0x100 data=7 -> read x3 gives busy=1, tag=0x104; data[3]=7 internally.
- Same cycle: commit rd=4 pc=0x200 data=9 and issue rd=4 pc=0x208 -> x4 busy=1, tag=0x208. After commit pc=0x208 data=1, read gives 1.
- Rename x1, x2, x7, then assert exception together with commit rd=1 pc=tag, data=0x44 and an issue -> no is_valid pulse; all busy=0; x1 reads 0x44.
- Issue writing rd=0 pc=0x300, then commit rd=0 data=5 -> x0 reads busy=0, data=0.
- With RF_COMMIT_FORWARD_EN, read x3 the same cycle as its matching commit data=0x55 -> busy1=0, data1=0x55. Without the macro -> busy1=1, tag1 equal to that commit's PC.
- Assert rst low between clock edges while x5 is busy -> outputs 0 and x5 not busy immediately, before the next edge.
